fifo_fwft_flex: RTL

//  First-word-fall-through FIFO with self-contained storage, used between the memory

---
 rtl/fifo_fwft_flex.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fifo_fwft_flex.sv
// First-word-fall-through FIFO: RAM plus output register, any depth,
// occupancy count, programmable level flags and sticky error flags.
module fifo_fwft_flex #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int EARLY_FULL   = 0,
    parameter int AFULL_LEVEL  = RAM_DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    localparam int CAP         = RAM_DEPTH + 1,
    localparam int CNT_W       = $clog2(CAP + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int RC_W = $clog2(RAM_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(CAP - EARLY_FULL);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_LEVEL);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AEMPTY_LEVEL);
    localparam logic RST_FULL = (EARLY_FULL >= CAP);

    logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];

    logic                  active_q, active_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RC_W-1:0]       ram_cnt_q, ram_cnt_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic live;
    logic push_acc;
    logic pop_acc;
    logic rd;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(
        input logic [ADDR_WIDTH-1:0] p
    );
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Refill the output register whenever it is free or being consumed.
    always_comb begin
        live     = active_q && !clear;
        push_acc = live && push && !full_q;
        pop_acc  = live && pop && dout_valid_q;
        rd       = (ram_cnt_q != '0) && (!dout_valid_q || pop_acc);
    end

    always_comb begin
        active_d     = 1'b1;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_cnt_d    = ram_cnt_q;
        dout_valid_d = dout_valid_q;
        data_out_d   = data_out_q;
        count_d      = count_q;
        full_d       = full_q;
        afull_d      = afull_q;
        aempty_d     = aempty_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        if (active_q && clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            ram_cnt_d    = '0;
            dout_valid_d = 1'b0;
            count_d      = '0;
            full_d       = RST_FULL;
            afull_d      = 1'b0;
            aempty_d     = 1'b1;
            ovf_d        = 1'b0;
            udf_d        = 1'b0;
        end else if (active_q) begin
            if (push_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd) begin
                rd_ptr_d     = ptr_inc(rd_ptr_q);
                data_out_d   = ram[rd_ptr_q];
                dout_valid_d = 1'b1;
            end else if (pop_acc) begin
                dout_valid_d = 1'b0;
            end
            case ({push_acc, rd})
                2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
                2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
                default: ram_cnt_d = ram_cnt_q;
            endcase
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            full_d   = (count_d >= FULL_LVL);
            afull_d  = (count_d >= AF_LVL);
            aempty_d = (count_d <= AE_LVL);
            ovf_d    = ovf_q | (push && full_q);
            udf_d    = udf_q | (pop && !dout_valid_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            ram[wr_ptr_q] <= data_in;
        end
    end

    // active_q delays reset removal by one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            dout_valid_q <= 1'b0;
            data_out_q   <= '0;
            count_q      <= '0;
            full_q       <= RST_FULL;
            afull_q      <= 1'b0;
            aempty_q     <= 1'b1;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            active_q     <= active_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_cnt_q    <= ram_cnt_d;
            dout_valid_q <= dout_valid_d;
            data_out_q   <= data_out_d;
            count_q      <= count_d;
            full_q       <= full_d;
            afull_q      <= afull_d;
            aempty_q     <= aempty_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
        end
    end

    assign data_out     = data_out_q;
    assign empty        = !dout_valid_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
